// File: rtl/elbeth_hazard_ctrl.sv
// Hazard controller for the ELBETH 5-stage core: load-use stalls, branch flushes,
// dmem freezes, and registered EX forwarding selects. Optional perf counters: ELBETH_HAZARD_PERF_EN.
module elbeth_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_stall,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            ex_fwd_a_sel,
  output logic [1:0]            ex_fwd_b_sel
`ifdef ELBETH_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_lu_stalls,
  output logic [CNT_W-1:0]      perf_br_flushes,
  output logic [CNT_W-1:0]      perf_dmem_stalls
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } tag_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_LOAD_USE,
    ACT_BRANCH,
    ACT_DMEM
  } act_e;

  tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fwd_e fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic quiet_q;
  logic lu_hit;
  act_e act;

  function automatic logic tag_live(tag_t t);
    return t.valid & t.we & (t.rd != '0);
  endfunction

  // The EX producer is younger than MEM, so it wins; a load in EX cannot forward yet.
  function automatic fwd_e fwd_pick(logic uses, logic [REG_ADDR_W-1:0] rs, tag_t ex_t, tag_t mem_t);
    fwd_pick = FWD_RF;
    if (uses && rs != '0) begin
      if (tag_live(ex_t) && rs == ex_t.rd && !ex_t.is_load) fwd_pick = FWD_MEM;
      else if (tag_live(mem_t) && rs == mem_t.rd)            fwd_pick = FWD_WB;
    end
  endfunction

  assign lu_hit = tag_live(ex_q) & ex_q.is_load & id_valid &
                  ((id_uses_rs1 & (id_rs1_addr == ex_q.rd)) |
                   (id_uses_rs2 & (id_rs2_addr == ex_q.rd)));

  // The cycle after reset is kept quiet: no stall or flush is raised whatever the inputs.
  always_comb begin
    if (rst || quiet_q)       act = ACT_ADVANCE;
    else if (dmem_stall)      act = ACT_DMEM;
    else if (ex_branch_taken) act = ACT_BRANCH;
    else if (lu_hit)          act = ACT_LOAD_USE;
    else                      act = ACT_ADVANCE;
  end

  always_comb begin
    pc_stall    = (act == ACT_DMEM) || (act == ACT_LOAD_USE);
    if_id_stall = (act == ACT_DMEM) || (act == ACT_LOAD_USE);
    if_id_flush = (act == ACT_BRANCH);
    id_ex_flush = (act == ACT_BRANCH) || (act == ACT_LOAD_USE);
  end

  // NOTE: every next-state signal is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    unique case (act)
      ACT_DMEM: ;
      ACT_BRANCH, ACT_LOAD_USE: begin
        ex_d    = '0;
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end
      default: begin
        ex_d    = '{valid: id_valid, rd: id_rd_addr, we: id_reg_write, is_load: id_mem_read};
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwd_a_d = fwd_pick(id_uses_rs1, id_rs1_addr, ex_q, mem_q);
        fwd_b_d = fwd_pick(id_uses_rs2, id_rs2_addr, ex_q, mem_q);
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      quiet_q <= 1'b1;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      quiet_q <= 1'b0;
    end
  end

  assign ex_fwd_a_sel = fwd_a_q;
  assign ex_fwd_b_sel = fwd_b_q;

`ifdef ELBETH_HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, br_cnt_q, dm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q <= '0;
      br_cnt_q <= '0;
      dm_cnt_q <= '0;
    end else begin
      if (act == ACT_LOAD_USE && lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      if (act == ACT_BRANCH   && br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (act == ACT_DMEM     && dm_cnt_q != '1) dm_cnt_q <= dm_cnt_q + CNT_W'(1);
    end
  end

  assign perf_lu_stalls   = lu_cnt_q;
  assign perf_br_flushes  = br_cnt_q;
  assign perf_dmem_stalls = dm_cnt_q;
`endif

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Self-checking bench for elbeth_hazard_ctrl: directed hazard scenarios followed by
// random traffic compared against a stage-array reference model.
module tb_elbeth_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic       ex_branch_taken, dmem_stall;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
`ifdef ELBETH_HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_br_flushes, perf_dmem_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elbeth_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rd_addr      (id_rd_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_stall      (dmem_stall),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_fwd_a_sel    (ex_fwd_a_sel),
    .ex_fwd_b_sel    (ex_fwd_b_sel)
`ifdef ELBETH_HAZARD_PERF_EN
    ,
    .perf_lu_stalls  (perf_lu_stalls),
    .perf_br_flushes (perf_br_flushes),
    .perf_dmem_stalls(perf_dmem_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB occupants.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } slot_t;

  slot_t pipe[3];
  int    m_fa, m_fb;
  bit    m_quiet;

  function automatic bit live(slot_t s);
    return s.v && s.we && s.rd != 0;
  endfunction

  // 0 = advance, 1 = dmem freeze, 2 = branch flush, 3 = load-use bubble
  function automatic int model_mode();
    bit dep;
    if (rst || m_quiet) return 0;
    if (dmem_stall) return 1;
    if (ex_branch_taken) return 2;
    dep = (id_uses_rs1 && int'(id_rs1_addr) == pipe[0].rd) ||
          (id_uses_rs2 && int'(id_rs2_addr) == pipe[0].rd);
    if (live(pipe[0]) && pipe[0].ld && id_valid && dep) return 3;
    return 0;
  endfunction

  function automatic int model_fwd(bit uses, int rs);
    if (!uses || rs == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (live(pipe[k]) && pipe[k].rd == rs && !(k == 0 && pipe[k].ld)) return k + 1;
    return 0;
  endfunction

  task automatic model_check();
    int m;
    m = model_mode();
    check("pc_stall",    32'(pc_stall),    32'(m == 1 || m == 3));
    check("if_id_stall", 32'(if_id_stall), 32'(m == 1 || m == 3));
    check("if_id_flush", 32'(if_id_flush), 32'(m == 2));
    check("id_ex_flush", 32'(id_ex_flush), 32'(m == 2 || m == 3));
    check("fwd_a",       32'(ex_fwd_a_sel), 32'(m_fa));
    check("fwd_b",       32'(ex_fwd_b_sel), 32'(m_fb));
  endtask

  task automatic model_step();
    int    m, na, nb;
    slot_t bubble;
    bubble = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = bubble;
      m_fa = 0;
      m_fb = 0;
      m_quiet = 1'b1;
      return;
    end
    m = model_mode();
    m_quiet = 1'b0;
    if (m == 1) return;
    na = (m == 0) ? model_fwd(id_uses_rs1, int'(id_rs1_addr)) : 0;
    nb = (m == 0) ? model_fwd(id_uses_rs2, int'(id_rs2_addr)) : 0;
    for (int k = 2; k > 0; k--) pipe[k] = pipe[k-1];
    if (m == 0) pipe[0] = '{v: id_valid, rd: int'(id_rd_addr), we: id_reg_write, ld: id_mem_read};
    else        pipe[0] = bubble;
    m_fa = na;
    m_fb = nb;
  endtask

  task automatic apply(input bit r, input bit v, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit we, input bit ld,
                       input bit br, input bit dm);
    @(negedge clk);
    rst = r;  id_valid = v;
    id_rs1_addr = 5'(rs1); id_rs2_addr = 5'(rs2); id_rd_addr = 5'(rd);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = we; id_mem_read = ld;
    ex_branch_taken = br; dmem_stall = dm;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
  endtask

  initial begin
    bit pr;
    bit r, br, dm;
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    m_fa = 0; m_fb = 0; m_quiet = 1'b0;
    rst = 1'b1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_mem_read = 0;
    ex_branch_taken = 0; dmem_stall = 0;
    @(posedge clk);
    model_step();
    idle();
    check("rst_fwd_a", 32'(ex_fwd_a_sel), 32'd0);

    // lw x5 ; add x6,x5,x7 -> one bubble, then WB forward on A
    do_reset();
    apply(0, 1, 1, 0, 5, 1, 0, 1, 1, 0, 0); tick();
    apply(0, 1, 5, 7, 6, 1, 1, 1, 0, 0, 0);
    check("lu_pc_stall", 32'(pc_stall), 32'd1);
    check("lu_idex_flush", 32'(id_ex_flush), 32'd1);
    tick();
    apply(0, 1, 5, 7, 6, 1, 1, 1, 0, 0, 0);
    check("lu_single_bubble", 32'(pc_stall), 32'd0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_fwd_a", 32'(ex_fwd_a_sel), 32'd2);
    check("lu_fwd_b", 32'(ex_fwd_b_sel), 32'd0);
    tick();

    // add x3 ; sub x4,x3,x3 -> MEM forward on both operands
    do_reset();
    apply(0, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0); tick();
    apply(0, 1, 3, 3, 4, 1, 1, 1, 0, 0, 0);
    check("raw_no_stall", 32'(pc_stall), 32'd0);
    tick();
    idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // addi x0 ; add x1,x0,x0 -> no dependency through x0
    do_reset();
    apply(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0); tick();
    apply(0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_fwd_a", 32'(ex_fwd_a_sel), 32'd0);
    check("x0_fwd_b", 32'(ex_fwd_b_sel), 32'd0);
    tick();

    // add x3 ; nop ; or x8,x9,x3 -> WB forward on B
    do_reset();
    apply(0, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0); tick();
    apply(0, 1, 9, 3, 8, 1, 1, 1, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("gap_fwd_b", 32'(ex_fwd_b_sel), 32'd2);
    tick();

    // branch held under dmem_stall for 3 cycles, acted on afterwards
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 2, 3, 1, 1, 1, 0, 1, 1);
      check("brdm_pc_stall", 32'(pc_stall), 32'd1);
      check("brdm_no_flush", 32'(if_id_flush), 32'd0);
      tick();
    end
    apply(0, 1, 1, 2, 3, 1, 1, 1, 0, 1, 0);
    check("br_if_flush", 32'(if_id_flush), 32'd1);
    check("br_ex_flush", 32'(id_ex_flush), 32'd1);
    tick();

    // reset in the middle of a load-use stall
    do_reset();
    apply(0, 1, 1, 0, 5, 1, 0, 1, 1, 0, 0); tick();
    apply(1, 1, 5, 0, 6, 1, 0, 1, 0, 0, 0);
    check("rst_lu_pc", 32'(pc_stall), 32'd0);
    tick();
    apply(0, 1, 5, 0, 6, 1, 0, 1, 0, 0, 0);
    check("rst_lu_gone", 32'(pc_stall), 32'd0);
    check("rst_lu_flush", 32'(id_ex_flush), 32'd0);
    tick();

    // random traffic over a small register range to provoke hazards
    pr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      br = !pr && ($urandom_range(0, 99) < 15);
      dm = !pr && ($urandom_range(0, 99) < 20);
      apply(r, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 35), br, dm);
      tick();
      pr = r;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elbeth_hazard_ctrl.md
Name: elbeth_hazard_ctrl

Overview:
Pipeline hazard controller for the ELBETH 5-stage core (IF/ID/EX/MEM/WB). It sits beside the decoder and consumes the decoder's id_rs1_addr/id_rs2_addr/id_rd_addr plus per-instruction control flags. It keeps its own shadow tags of the EX/MEM/WB destination registers and drives stall, flush and registered forwarding selects. It sequences the datapath through load-use stalls, taken-branch flushes and data-memory wait states.

Parameters:
REG_ADDR_W, 5, register address width (32 GPRs, x0 hardwired zero)
CNT_W, 32, width of perf counters (only with the optional feature)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_rs1_addr  input  REG_ADDR_W  rs1 from decoder
id_rs2_addr  input  REG_ADDR_W  rs2 from decoder
id_rd_addr  input  REG_ADDR_W  rd from decoder
id_uses_rs1  input  1  instruction reads rs1
id_uses_rs2  input  1  instruction reads rs2
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
ex_branch_taken  input  1  branch/jump in EX redirects PC this cycle
dmem_stall  input  1  data memory not ready; whole pipeline must freeze
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  IF/ID loads a bubble
id_ex_flush  output  1  ID/EX loads a bubble
ex_fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage result
ex_fwd_b_sel  output  2  same for operand B

Behaviour:
- Stall/flush outputs are combinational from current inputs and shadow tags; fwd selects are registered (describe the instruction currently in EX).
- Shadow tags: per stage EX, MEM, WB: valid, rd, we, is_load. A tag is "live" when valid & we & rd != 0.
- Priority per cycle, highest first:
  1. dmem_stall=1: pc_stall=1, if_id_stall=1, both flushes 0; tags and fwd selects hold. A simultaneous ex_branch_taken is ignored this cycle; dmem_stall keeps it in EX and it is acted on in the first cycle dmem_stall is 0.
  2. ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, no stalls; EX tag <- bubble; MEM<-EX, WB<-MEM; fwd selects <- 00. This overrides any load-use condition.
  3. Load-use: EX tag live & is_load & id_valid & ((id_uses_rs1 & rs1==EX.rd) | (id_uses_rs2 & rs2==EX.rd)): pc_stall=1, if_id_stall=1, id_ex_flush=1; EX<-bubble, pipeline shifts. Exactly one bubble per load-use pair; the next cycle forwards from WB (sel 10).
  4. Otherwise: advance; EX tag <- {id_valid, id_rd_addr, id_reg_write, id_mem_read}, MEM<-EX, WB<-MEM.
- Forward select, computed when the ID instruction advances into EX (cases 3 and 4 compute a new EX value; in case 3 it is 00 because EX receives a bubble):
  - id_uses_rsX & rsX!=0 & current EX tag live & rsX==EX.rd & !EX.is_load -> 01.
  - else id_uses_rsX & rsX!=0 & current MEM tag live & rsX==MEM.rd -> 10.
  - else 00. The younger producer (EX) wins over MEM.
- Regfile is write-before-read; WB-to-ID same-cycle hazard is not handled here.
- rd=0 never creates a dependency or forward.
- Reset (any cycle, including mid-stall): all tags invalid, fwd selects 00, all stall/flush outputs 0 in the reset cycle and the cycle after.

Optional Feature:
ELBETH_HAZARD_PERF_EN: adds outputs perf_lu_stalls, perf_br_flushes, perf_dmem_stalls (CNT_W each). Each counts cycles in which the case 3, case 2 or case 1 condition respectively is active. Counters saturate at all-ones and clear on rst. Without the macro these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- lw x5 then add x6,x5,x7 (rs1=5) -> one cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1; the add enters EX with ex_fwd_a_sel=10, ex_fwd_b_sel=00.
- add x3,.. then sub x4,x3,x3 back-to-back -> no stall; sub in EX has fwd_a=fwd_b=01.
- addi x0,.. then add x1,x0,x0 -> no stall, fwd selects 00.
- add x3 then nop then or x8,x9,x3 -> or in EX has fwd_b=10.
- ex_branch_taken=1 together with dmem_stall=1 for 3 cycles -> flushes 0 for those 3 cycles, pc_stall=1; then if_id_flush=id_ex_flush=1 for one cycle.
- rst asserted during a load-use stall -> next cycle outputs 0, tags cleared, and the former dependent instruction causes no stall.
